line_arbiter: RTL and testbench
===============================

# line_arbiter

Two-client, 256-bit cache-line arbiter that sits directly upstream of the physical memory model. It merges the instruction-cache line port and the data-cache line port onto the single memory port. It serializes the two clients' requests, holds the winner's request stable until memory responds, and routes the response and read data back to the winner. It is correct for both zero-latency memory (response in the same cycle the request is presented) and multi-cycle memory.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports
- LINE_W, 256, line width of all data ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- i_read  in  1  I-cache line read request
- i_write  in  1  I-cache line write request (normally 0)
- i_address  in  ADDR_W  I-cache line address
- i_wdata  in  LINE_W  I-cache write line
- i_resp  out  1  I-cache transaction complete
- i_rdata  out  LINE_W  I-cache read line
- d_read  in  1  D-cache line read request
- d_write  in  1  D-cache line write request (writeback)
- d_address  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache write line
- d_resp  out  1  D-cache transaction complete
- d_rdata  out  LINE_W  D-cache read line
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  ADDR_W  memory address
- pmem_wdata  out  LINE_W  memory write line
- pmem_resp  in  1  memory response
- pmem_rdata  in  LINE_W  memory read line

## Operation
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE:
  - A port is requesting when its read|write is high.
  - If only one port is requesting, grant it.
  - If both are requesting, resolve per Configuration.
  - On grant, latch the winner's address, wdata and op into internal registers, then go to BUSY_I or BUSY_D.
  - If a port asserts both read and write, the write wins and read is ignored.
- BUSY_x:
  - pmem_read/pmem_write/pmem_address/pmem_wdata are driven from the latched registers only. Client inputs may change without effect.
  - x_resp = pmem_resp (combinational).
  - x_rdata = pmem_rdata.
  - On pmem_resp, go to DONE.
- DONE: one cycle; pmem strobes 0, all resp 0; requests are ignored. Go to IDLE. This guarantees that a client which lowers its request on the edge after resp is never serviced twice.
- The non-granted client always sees resp=0 and rdata=0.
- Outputs in IDLE and DONE:
  - pmem_read=0, pmem_write=0.
  - pmem_address and pmem_wdata hold their last latched values.
- Outputs after reset:
  - State IDLE.
  - All latched registers 0.
  - pmem_read=0, pmem_write=0, i_resp=0, d_resp=0.
  - i_rdata=0, d_rdata=0.
  - Round-robin pointer favours D.
- Reset mid-transaction: the FSM returns to IDLE on that edge. Strobes are 0 from the next cycle. No resp is produced for the aborted transaction, even if pmem_resp arrives later.
- A pmem_resp received outside BUSY_x is ignored.

## Timing
- Request visible in IDLE at cycle N:
  - Grant at edge N→N+1.
  - pmem strobe high throughout cycle N+1.
- Zero-latency memory:
  - x_resp high in cycle N+1.
  - DONE in cycle N+2.
  - IDLE in cycle N+3.
  - A new grant can be made at the end of N+3.
- Memory with response in cycle N+k (k≥1): x_resp is high in cycle N+k only. Total occupancy is k+2 cycles.
- pmem strobes are never high in two transactions without an intervening DONE cycle.

## Configuration
- ARBITER_ROUND_ROBIN_EN defined:
  - On a simultaneous request, grant the port not served by the most recent grant.
  - The pointer updates on every grant.
  - A lone requester is always granted regardless of the pointer.
- Not defined:
  - Fixed priority: D always wins a simultaneous request. The D-cache miss path stalls the pipeline.
  - No pointer register exists.

## Structure
- Shared package `line_arb_pkg`:
  - State enum `arb_state_t` (IDLE, BUSY_I, BUSY_D, DONE).
  - Localparams for the default ADDR_W/LINE_W.
  - Client-select enum `arb_client_t` (CLIENT_I, CLIENT_D).
- Optional sub-module `line_arb_req_reg`: the latched address/wdata/op register with load enable and synchronous reset. Everything else is in the top module.

## Test plan
- I read only, addr 0x0000_0040, zero-latency memory:
  - pmem_read=1 and pmem_address=0x40 in cycle N+1.
  - i_resp=1 in N+1, with i_rdata equal to the memory line.
  - d_resp=0 throughout.
- Simultaneous I read 0x80 and D write 0x100, fixed priority:
  - D is served first: pmem_write=1, address 0x100.
  - I is served after DONE/IDLE: pmem_read=1, address 0x80.
- Same simultaneous stimulus repeated three times, ARBITER_ROUND_ROBIN_EN defined:
  - Grants alternate D, I, D, I, D, I.
- D read, memory delayed k=4; d_address changes to 0x200 mid-transaction:
  - pmem_address stays at the original value throughout.
  - d_resp is high only in cycle N+4.
- rst asserted in BUSY_D cycle 2 with memory k=5:
  - pmem_read=0 from the next cycle.
  - No d_resp at all, including when the late pmem_resp arrives.
- Client holds d_read high through the DONE cycle, then lowers it:
  - Exactly one transaction is issued.

Source files
------------

// File: rtl/line_arb_pkg.sv
// ============================================================================
// Package  : line_arb_pkg
// Brief    : Shared types and default widths for the cache-line arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package line_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        CLIENT_I = 1'b0,
        CLIENT_D = 1'b1
    } arb_client_t;

endpackage

`default_nettype wire

// File: rtl/line_arb_req_reg.sv
// ============================================================================
// Module   : line_arb_req_reg
// Brief    : Latched copy of the granted request (op, address, write line).
// Revision : 1.0
// ============================================================================
`default_nettype none

module line_arb_req_reg
    import line_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic              read_o,
    output logic              write_o,
    output logic [ADDR_W-1:0] address_o,
    output logic [LINE_W-1:0] wdata_o
);

    logic              read_q;
    logic              write_q;
    logic [ADDR_W-1:0] address_q;
    logic [LINE_W-1:0] wdata_q;

    // A client raising both strobes is treated as a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            address_q <= '0;
            wdata_q   <= '0;
        end else if (load_i) begin
            read_q    <= read_i & ~write_i;
            write_q   <= write_i;
            address_q <= address_i;
            wdata_q   <= wdata_i;
        end
    end

    assign read_o    = read_q;
    assign write_o   = write_q;
    assign address_o = address_q;
    assign wdata_o   = wdata_q;

endmodule

`default_nettype wire

// File: rtl/line_arbiter.sv
// ============================================================================
// Module   : line_arbiter
// Brief    : Merges I-cache and D-cache line ports onto one memory port.
//            Define ARBITER_ROUND_ROBIN_EN for round-robin tie-break,
//            otherwise D-cache has fixed priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module line_arbiter
    import line_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [LINE_W-1:0] i_wdata,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    arb_client_t       win;
    logic              i_req;
    logic              d_req;
    logic              grant;
    logic              sel_read;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_address;
    logic [LINE_W-1:0] sel_wdata;
    logic              op_read_q;
    logic              op_write_q;
    logic              busy;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;
    assign grant = (state_q == IDLE) && (i_req || d_req);

`ifdef ARBITER_ROUND_ROBIN_EN
    arb_client_t last_q;

    // Reset value CLIENT_I makes the first contested grant go to D.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= CLIENT_I;
        end else if (grant) begin
            last_q <= win;
        end
    end

    always_comb begin
        win = CLIENT_I;
        if (d_req && (!i_req || (last_q == CLIENT_I))) begin
            win = CLIENT_D;
        end
    end
`else
    always_comb begin
        win = d_req ? CLIENT_D : CLIENT_I;
    end
`endif

    always_comb begin
        sel_read    = i_read;
        sel_write   = i_write;
        sel_address = i_address;
        sel_wdata   = i_wdata;
        if (win == CLIENT_D) begin
            sel_read    = d_read;
            sel_write   = d_write;
            sel_address = d_address;
            sel_wdata   = d_wdata;
        end
    end

    line_arb_req_reg #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_req_reg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (grant),
        .read_i    (sel_read),
        .write_i   (sel_write),
        .address_i (sel_address),
        .wdata_i   (sel_wdata),
        .read_o    (op_read_q),
        .write_o   (op_write_q),
        .address_o (pmem_address),
        .wdata_o   (pmem_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE is a mandatory gap so a client dropping its request on the
    // edge after resp is never granted twice.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = (win == CLIENT_D) ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (pmem_resp) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign pmem_read  = busy & op_read_q;
    assign pmem_write = busy & op_write_q;

    // Responses are suppressed while reset aborts the transaction.
    assign i_resp  = (state_q == BUSY_I) & pmem_resp & ~rst;
    assign d_resp  = (state_q == BUSY_D) & pmem_resp & ~rst;
    assign i_rdata = (state_q == BUSY_I) ? pmem_rdata : '0;
    assign d_rdata = (state_q == BUSY_D) ? pmem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_line_arbiter.sv
// ============================================================================
// Module   : tb_line_arbiter
// Brief    : Self-checking bench for line_arbiter with a transaction-level
//            reference model and a variable-latency memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_line_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, i_write, i_resp;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_wdata, i_rdata;
    logic          d_read, d_write, d_resp;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata, d_rdata;
    logic          pmem_read, pmem_write, pmem_resp;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata, pmem_rdata;

    always #5 clk = ~clk;

    line_arbiter dut (
        .clk (clk), .rst (rst),
        .i_read (i_read), .i_write (i_write), .i_address (i_address),
        .i_wdata (i_wdata), .i_resp (i_resp), .i_rdata (i_rdata),
        .d_read (d_read), .d_write (d_write), .d_address (d_address),
        .d_wdata (d_wdata), .d_resp (d_resp), .d_rdata (d_rdata),
        .pmem_read (pmem_read), .pmem_write (pmem_write),
        .pmem_address (pmem_address), .pmem_wdata (pmem_wdata),
        .pmem_resp (pmem_resp), .pmem_rdata (pmem_rdata)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory environment
    bit mem_rand    = 1'b0;
    int mem_lat_fix = 0;
    int spur_pct    = 0;
    bit spur_force  = 1'b0;
    bit mem_prev    = 1'b0;
    int mem_cnt     = 0;
    int mem_lat     = 0;

    // Reference model: who owns the port, plus the one-cycle gap after completion
    int            m_own   = 0;   // 0 none, 1 I, 2 D
    bit            m_gap   = 1'b0;
    bit            m_last  = 1'b0; // 1 when D was served last
    logic          m_rd    = 1'b0;
    logic          m_wr    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [LW-1:0] m_wdata = '0;

    // Client drivers and scoreboard (index 0 = I, 1 = D)
    bit            gen_en = 1'b0;
    bit            act[2], drop_in[2], hold[2], seen[2];
    int            issued[2], done_cnt[2];
    logic          cur_rd[2], cur_wr[2];
    logic [AW-1:0] cur_addr[2];
    logic [LW-1:0] cur_wd[2];
    int            cyc = 0;
    bit            prev_strobe = 1'b0;
    bit            log_wr[$];
    logic [AW-1:0] log_addr[$];

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] t;
        t = $urandom;
        return {t[AW-1:5], 5'b0};
    endfunction

    task automatic apply(input int c);
        if (c == 0) begin
            i_read = cur_rd[0]; i_write = cur_wr[0]; i_address = cur_addr[0]; i_wdata = cur_wd[0];
        end else begin
            d_read = cur_rd[1]; d_write = cur_wr[1]; d_address = cur_addr[1]; d_wdata = cur_wd[1];
        end
    endtask

    task automatic start_req(input int c, input logic rd, input logic wr,
                             input logic [AW-1:0] a, input logic [LW-1:0] w, input bit hx);
        cur_rd[c] = rd; cur_wr[c] = wr; cur_addr[c] = a; cur_wd[c] = w;
        act[c] = 1'b1; hold[c] = hx; drop_in[c] = 1'b0; issued[c]++;
        apply(c);
    endtask

    task automatic drop_req(input int c);
        act[c] = 1'b0; cur_rd[c] = 1'b0; cur_wr[c] = 1'b0;
        apply(c);
    endtask

    task automatic drive_clients();
        int r;
        for (int c = 0; c < 2; c++) begin
            if (drop_in[c]) begin
                drop_in[c] = 1'b0;
                drop_req(c);
            end else if (act[c] && seen[c]) begin
                if (hold[c]) begin
                    hold[c] = 1'b0;
                    drop_in[c] = 1'b1;
                end else begin
                    drop_req(c);
                end
            end else if (act[c]) begin
                if (gen_en && $urandom_range(0, 9) == 0) begin
                    cur_addr[c] = rand_addr();
                    cur_wd[c] = rand_line();
                    apply(c);
                end
            end else if (gen_en && $urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 9);
                start_req(c, (r < 6) || (r >= 8), r >= 6, rand_addr(), rand_line(),
                          $urandom_range(0, 2) == 0);
            end
        end
    endtask

    task automatic model_advance();
        bit ir, dr, wd;
        if (rst) begin
            m_own = 0; m_gap = 1'b0; m_last = 1'b0;
            m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
        end else if (m_own != 0) begin
            if (pmem_resp) begin
                m_own = 0;
                m_gap = 1'b1;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            ir = i_read | i_write;
            dr = d_read | d_write;
            if (ir || dr) begin
`ifdef ARBITER_ROUND_ROBIN_EN
                wd = (ir && dr) ? !m_last : dr;
`else
                wd = dr;
`endif
                if (wd) begin
                    m_wr = d_write; m_rd = d_read & !d_write; m_addr = d_address; m_wdata = d_wdata;
                end else begin
                    m_wr = i_write; m_rd = i_read & !i_write; m_addr = i_address; m_wdata = i_wdata;
                end
                m_own = wd ? 2 : 1;
                m_last = wd;
            end
        end
    endtask

    task automatic finish_cycle();
        bit s;
        @(negedge clk);
        s = pmem_read | pmem_write;
        if (s) begin
            if (!mem_prev) begin
                mem_cnt = 0;
                mem_lat = mem_rand ? $urandom_range(0, 4) : mem_lat_fix;
            end
            pmem_rdata = rand_line();
            if (mem_cnt == mem_lat) begin
                pmem_resp = 1'b1;
            end else begin
                pmem_resp = 1'b0;
                mem_cnt++;
            end
        end else begin
            pmem_rdata = rand_line();
            pmem_resp = spur_force || ((spur_pct > 0) && ($urandom_range(0, 99) < spur_pct));
        end
        mem_prev = s;
        #1;
        cyc++;
        if (s && !prev_strobe) begin
            log_wr.push_back(pmem_write);
            log_addr.push_back(pmem_address);
        end
        prev_strobe = s;

        check("pmem_read",    pmem_read,    (m_own != 0) && m_rd);
        check("pmem_write",   pmem_write,   (m_own != 0) && m_wr);
        check("pmem_address", pmem_address, m_addr);
        check("pmem_wdata",   pmem_wdata,   m_wdata);
        check("i_resp",       i_resp,       (m_own == 1) && pmem_resp && !rst);
        check("d_resp",       d_resp,       (m_own == 2) && pmem_resp && !rst);
        check("i_rdata",      i_rdata,      (m_own == 1) ? pmem_rdata : '0);
        check("d_rdata",      d_rdata,      (m_own == 2) ? pmem_rdata : '0);

        seen[0] = i_resp;
        seen[1] = d_resp;
        if (i_resp) begin done_cnt[0]++; check("i_resp_unrequested", act[0], 1); end
        if (d_resp) begin done_cnt[1]++; check("d_resp_unrequested", act[1], 1); end
        model_advance();
    endtask

    task automatic pre();
        @(posedge clk);
        #1;
        drive_clients();
    endtask

    task automatic tick();
        pre();
        finish_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, d0, nc;
        rst = 1'b1;
        i_read = 0; i_write = 0; i_address = '0; i_wdata = '0;
        d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        for (int c = 0; c < 2; c++) begin
            act[c] = 0; drop_in[c] = 0; hold[c] = 0; seen[c] = 0;
            issued[c] = 0; done_cnt[c] = 0;
            cur_rd[c] = 0; cur_wr[c] = 0; cur_addr[c] = '0; cur_wd[c] = '0;
        end
        @(posedge clk);
        repeat (2) tick();
        pre(); rst = 1'b0; finish_cycle();
        check("reset_pmem_addr", pmem_address, 0);

        // I read 0x40, zero-latency memory
        d0 = done_cnt[1];
        pre(); start_req(0, 1, 0, 32'h40, rand_line(), 0); finish_cycle();
        pre(); finish_cycle();
        check("t1_pmem_read", pmem_read, 1);
        check("t1_pmem_addr", pmem_address, 32'h40);
        check("t1_i_resp", i_resp, 1);
        check("t1_i_rdata", i_rdata, pmem_rdata);
        repeat (4) tick();
        check("t1_no_d_resp", done_cnt[1] - d0, 0);

        // Simultaneous I read 0x80 / D write 0x100, then three more rounds
        base = log_addr.size();
        for (int r = 0; r < 4; r++) begin
            pre();
            start_req(0, 1, 0, 32'h80, rand_line(), 0);
            start_req(1, 0, 1, 32'h100, rand_line(), 0);
            finish_cycle();
            repeat (8) tick();
        end
        check("t2_log_size", log_addr.size() - base, 8);
        for (int r = 0; r < 8; r++) begin
            if (base + r < log_addr.size()) begin
                check("t2_grant_op", log_wr[base + r], (r % 2 == 0) ? 1 : 0);
                check("t2_grant_addr", log_addr[base + r], (r % 2 == 0) ? 32'h100 : 32'h80);
            end
        end

        // D read with k=4, address changed mid-transaction
        mem_lat_fix = 3;
        d0 = done_cnt[1];
        pre(); start_req(1, 1, 0, 32'h1C0, rand_line(), 0); finish_cycle();
        nc = cyc;
        for (int k = 1; k <= 6; k++) begin
            pre();
            if (k == 1) begin cur_addr[1] = 32'h200; apply(1); end
            finish_cycle();
            if (k <= 4) check("t4_pmem_addr", pmem_address, 32'h1C0);
            check("t4_d_resp", d_resp, cyc == nc + 4);
        end
        check("t4_one_resp", done_cnt[1] - d0, 1);

        // Reset in BUSY_D cycle 2 with k=5, late response ignored
        mem_lat_fix = 4;
        d0 = done_cnt[1];
        pre(); start_req(1, 1, 0, 32'h240, rand_line(), 0); finish_cycle();
        pre(); finish_cycle();
        pre(); rst = 1'b1; finish_cycle();
        check("t5_busy_before_rst", pmem_read, 1);
        pre(); rst = 1'b0; drop_req(1); issued[1]--; finish_cycle();
        check("t5_strobe_off", pmem_read, 0);
        for (int k = 0; k < 4; k++) begin
            pre(); spur_force = (k < 3); finish_cycle();
            check("t5_strobe_off_late", pmem_read, 0);
        end
        spur_force = 1'b0;
        check("t5_no_d_resp", done_cnt[1] - d0, 0);

        // D holds its request through DONE: exactly one transaction
        mem_lat_fix = 0;
        base = log_addr.size();
        d0 = done_cnt[1];
        pre(); start_req(1, 1, 0, 32'h300, rand_line(), 1); finish_cycle();
        repeat (8) tick();
        check("t6_one_txn", log_addr.size() - base, 1);
        check("t6_one_resp", done_cnt[1] - d0, 1);

        // Randomized traffic with random latency, spurious responses and resets
        mem_rand = 1'b1;
        spur_pct = 3;
        gen_en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            pre();
            rst = ($urandom_range(0, 299) == 0);
            finish_cycle();
        end
        gen_en = 1'b0;
        spur_pct = 0;
        for (int k = 0; k < 300 && (act[0] || act[1]); k++) begin
            pre(); rst = 1'b0; finish_cycle();
        end
        check("drain_idle", act[0] | act[1], 0);
        check("i_txn_count", done_cnt[0], issued[0]);
        check("d_txn_count", done_cnt[1], issued[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
